i2s_tx_dac: RTL
===============

// Module: i2s_tx_dac
// PURPOSE
//  Output stage for the ANC datapath: takes the one-cycle out_sample/out_valid pulse from anc_top and streams it to the
//  speaker DAC as an I2S master (generates sck/ws/sd). Mono sample is sent on both L and R slots. A small FIFO absorbs
//  jitter between the datapath sample rate and the DAC frame rate; underrun repeats the last sample.
// PARAMETERS
//  DATA_W      16  sample width, two's complement (matches anc_top out_sample)
//  SLOT_W      16  sck periods per channel slot; must be >= DATA_W (LSBs padded with 0)
//  SCK_DIV     8   clk cycles per sck period; even, >= 2
//  FIFO_DEPTH  4   sample FIFO entries; power of two
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous, active-high reset
//  in_sample    in   DATA_W  sample from anc_top (out_sample)
//  in_valid     in   1       one-cycle strobe; sample written to FIFO on this cycle, no backpressure
//  sck          out  1       I2S bit clock (clk/SCK_DIV, 50% duty)
//  ws           out  1       I2S word select: 0 = left, 1 = right
//  sd           out  1       I2S serial data, MSB first, changes on sck falling edge
//  underrun     out  1       one-cycle pulse: frame start found FIFO empty (last sample repeated)
//  overflow     out  1       sticky: in_valid while FIFO full (sample dropped); cleared only by rst
//  fifo_level   out  log2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): sck=0, ws=0, sd=0, underrun=0, overflow=0, fifo_level=0, hold register=0, FSM->IDLE,
//    divider and bit counter cleared. Reset mid-frame aborts the frame immediately; FIFO contents discarded.
//  - FSM: IDLE -> RUN when fifo_level becomes nonzero (first sample written); RUN never returns to IDLE except via rst.
//    In IDLE sck held 0, ws 0, sd 0 (DAC sees silence, no clock).
//  - Divider: in RUN, div_cnt counts 0..SCK_DIV-1; sck rises when div_cnt wraps to SCK_DIV/2, falls when it wraps to 0.
//    First sck falling edge (k=0) occurs SCK_DIV clk cycles after entering RUN.
//  - Bit counter k = 0..2*SLOT_W-1, advanced on each sck falling edge, wraps to 0.
//    sd at falling edge k: left slot k<SLOT_W -> frame[DATA_W-1-k]; right slot -> frame[DATA_W-1-(k-SLOT_W)];
//    bit indices below 0 drive 0. ws=1 for k in [SLOT_W-1, 2*SLOT_W-2], else 0 (standard I2S one-bit ws lead).
//  - Frame load: on the falling edge that makes k=0 (including first edge after IDLE), pop FIFO into frame register and
//    hold register. If FIFO empty at that edge: frame <- hold register (repeat last), underrun pulses 1 clk.
//  - FIFO: write when in_valid and not full. in_valid while full: sample dropped, overflow set. Simultaneous write and
//    pop on same clk: both occur, level unchanged; write into full FIFO with simultaneous pop is accepted (not overflow).
//  - Latency: sample written into empty FIFO in RUN is first driven (MSB) on sd at next k=0 edge.
//  - Arithmetic: no modification of sample values; pure bit serialisation.
// STRUCTURE
//  - Shared package anc_pkg: SAMPLE_W=16 constant, i2s_slot_e typedef (SLOT_L/SLOT_R), tx FSM state typedef.
//  - One sub-module: sync_fifo (parameterised width/depth, full/empty/level, sync active-high reset).
//  - Top of block: FSM, sck divider, bit counter, shift/frame register, hold register, status flags.
// TESTING
//  1. Reset: hold rst 3 clks mid-frame -> sck=ws=sd=0, overflow=0, fifo_level=0, FSM IDLE, no sck until next in_valid.
//  2. Single sample 16'hA5C3, SCK_DIV=8: sd on k=0..15 = 1010_0101_1100_0011, same on k=16..31; ws=1 exactly for k=15..30.
//  3. Underrun: one sample 16'h8001 then none -> underrun pulse at each later k=0; every frame repeats 16'h8001 on L and R.
//  4. Overflow: 5 in_valid pulses back-to-back in IDLE with FIFO_DEPTH=4 -> fifo_level=4, overflow=1 sticky, 5th dropped;
//     frames output samples 1..4 in order.
//  5. Simultaneous pop/push: FIFO full, in_valid on the k=0 pop cycle -> level stays 4, overflow stays 0, sample kept.
//  6. SLOT_W=32, DATA_W=16: sample 16'h7FFF -> sd = 0 then fifteen 1s then sixteen 0s per slot; frame = 64 sck periods.

Source files
------------

// File: rtl/i2s_tx_dac_pkg.sv
// Shared types for the I2S DAC output stage: sample width, slot select encoding
// and the transmitter FSM states.
package i2s_tx_dac_pkg;

   localparam int SAMPLE_W = 16;

   typedef enum logic {
      SLOT_L = 1'b0,
      SLOT_R = 1'b1
   } i2s_slot_e;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_RUN  = 1'b1
   } tx_state_e;

endpackage

// File: rtl/i2s_tx_dac_if.sv
// Sample input strobe, I2S pins and status flags of the DAC output stage.
// in_valid is a one-cycle strobe with no ready: a sample is offered once and is
// either stored or dropped (raising overflow) on that same clk edge.
interface i2s_tx_dac_if #(
   parameter int DATA_W = 16,
   parameter int LVL_W  = 3
);
   logic [DATA_W-1:0] in_sample;
   logic              in_valid;
   logic              sck;
   logic              ws;
   logic              sd;
   logic              underrun;
   logic              overflow;
   logic [LVL_W-1:0]  fifo_level;

   modport master (
      output in_sample, in_valid,
      input  sck, ws, sd, underrun, overflow, fifo_level
   );

   modport slave (
      input  in_sample, in_valid,
      output sck, ws, sd, underrun, overflow, fifo_level
   );
endinterface

// File: rtl/i2s_tx_dac_fifo.sv
// Small synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_wr, do_rd;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/i2s_tx_dac.sv
// I2S master transmitter: buffers mono samples in a FIFO and serialises each one
// onto both the left and right slots, repeating the last sample on underrun.
module i2s_tx_dac
   import i2s_tx_dac_pkg::*;
#(
   parameter int DATA_W     = SAMPLE_W,
   parameter int SLOT_W     = 16,
   parameter int SCK_DIV    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   i2s_tx_dac_if.slave bus,
   output tx_state_e   dbg_state
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W = $clog2(SCK_DIV);
   localparam int K_W   = $clog2(2 * SLOT_W);
   localparam int IDX_W = $clog2(DATA_W);

   tx_state_e         state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              sck_q, sck_d;
   logic [K_W-1:0]    k_q, k_d;
   logic              started_q, started_d;
   logic [DATA_W-1:0] frame_q, frame_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              sd_q, sd_d;
   i2s_slot_e         ws_q, ws_d;
   logic              underrun_q, underrun_d;
   logic              overflow_q, overflow_d;

   logic [K_W-1:0]    slot_pos;
   logic              pop;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_level;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.in_valid),
      .wr_data (bus.in_sample),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      sck_d      = sck_q;
      k_d        = k_q;
      started_d  = started_q;
      frame_d    = frame_q;
      hold_d     = hold_q;
      sd_d       = sd_q;
      ws_d       = ws_q;
      underrun_d = 1'b0;
      pop        = 1'b0;
      slot_pos   = '0;

      case (state_q)
         TX_IDLE: begin
            div_d     = '0;
            sck_d     = 1'b0;
            k_d       = '0;
            started_d = 1'b0;
            sd_d      = 1'b0;
            ws_d      = SLOT_L;
            if (fifo_level != '0) begin
               state_d = TX_RUN;
            end
         end
         TX_RUN: begin
            if (div_q == DIV_W'(SCK_DIV - 1)) begin
               // sck falling edge: advance the bit counter; the very first edge after IDLE lands on k=0
               div_d     = '0;
               sck_d     = 1'b0;
               started_d = 1'b1;
               k_d       = (!started_q || k_q == K_W'(2 * SLOT_W - 1)) ? '0 : k_q + K_W'(1);
               if (k_d == '0) begin
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     frame_d = fifo_rd_data;
                     hold_d  = fifo_rd_data;
                  end else begin
                     frame_d    = hold_q;
                     underrun_d = 1'b1;
                  end
               end
               slot_pos = (k_d < K_W'(SLOT_W)) ? k_d : k_d - K_W'(SLOT_W);
               sd_d     = (slot_pos < K_W'(DATA_W)) ?
                          frame_d[IDX_W'(K_W'(DATA_W - 1) - slot_pos)] : 1'b0;
               // ws leads the slot by one bit, as standard I2S framing expects
               ws_d     = (k_d >= K_W'(SLOT_W - 1) && k_d <= K_W'(2 * SLOT_W - 2)) ? SLOT_R : SLOT_L;
            end else begin
               div_d = div_q + DIV_W'(1);
               if (div_d == DIV_W'(SCK_DIV / 2)) begin
                  sck_d = 1'b1;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase

      overflow_d = overflow_q | (bus.in_valid & fifo_full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         div_q      <= '0;
         sck_q      <= 1'b0;
         k_q        <= '0;
         started_q  <= 1'b0;
         frame_q    <= '0;
         hold_q     <= '0;
         sd_q       <= 1'b0;
         ws_q       <= SLOT_L;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         sck_q      <= sck_d;
         k_q        <= k_d;
         started_q  <= started_d;
         frame_q    <= frame_d;
         hold_q     <= hold_d;
         sd_q       <= sd_d;
         ws_q       <= ws_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.sck        = sck_q;
   assign bus.ws         = ws_q;
   assign bus.sd         = sd_q;
   assign bus.underrun   = underrun_q;
   assign bus.overflow   = overflow_q;
   assign bus.fifo_level = fifo_level;
   assign dbg_state      = state_q;

endmodule
